regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
Parametrised general-purpose register file that replaces the fixed 16 x 32-bit discrete register bank in the datapath. It provides one write port, two registered read ports with write-to-read bypass, and a per-register busy scoreboard for pending multi-cycle producers such as MUL/DIV and memory loads. The control unit reserves a destination register at issue, and the write-back clears the reservation. Read ports flag a hazard when they return stale data.

Parameters:
WIDTH, 32, data width of each register
DEPTH, 16, number of registers
ADDR_W, 4, address width; 2**ADDR_W >= DEPTH is required
RESET_VAL, 0, value loaded into every register on reset

Ports:
clk  input  1  system clock, rising edge
clr  input  1  reset, synchronous, active-high
wr_en  input  1  write strobe
wr_addr  input  ADDR_W  write register index
wr_data  input  WIDTH  write data
rsv_en  input  1  reserve strobe (marks register pending)
rsv_addr  input  ADDR_W  register index to reserve
rd_en_a  input  1  read port A request
rd_addr_a  input  ADDR_W  read port A index
rd_data_a  output  WIDTH  read port A data, registered
rd_valid_a  output  1  rd_data_a updated this cycle
hazard_a  output  1  rd_data_a was read from a busy register
rd_en_b, rd_addr_b, rd_data_b, rd_valid_b, hazard_b: same as port A, for port B
busy  output  DEPTH  scoreboard bitmask; bit i set = register i pending
err  output  1  sticky out-of-range access flag

Behaviour:
- clk is the only clock. clr is synchronous and active-high, and it takes priority over every same-cycle operation.
- Reset state: all registers = RESET_VAL; busy = 0; rd_data_a/b = 0; rd_valid_a/b = 0; hazard_a/b = 0; err = 0.
- Write: if wr_en and wr_addr < DEPTH, the register is updated at the clock edge and busy[wr_addr] is cleared.
- Reserve: if rsv_en and rsv_addr < DEPTH, busy[rsv_addr] is set at the edge.
- Reserve and write to the same address in the same cycle:
  - Data is written.
  - busy stays set, because the new reservation wins.
- Reserve of an already-busy register: no change, and no error.
- Read latency is 1 cycle. When rd_en_x is sampled high at edge N, the following hold after edge N:
  - rd_data_x = wr_data if wr_en and wr_addr == rd_addr_x at edge N (bypass); otherwise the pre-edge stored value.
  - rd_valid_x = 1.
  - hazard_x = busy[rd_addr_x] (pre-edge value) AND NOT bypass hit.
- When rd_en_x is low: rd_data_x and hazard_x hold their previous values, and rd_valid_x = 0.
- Both read ports may target the same address, including the write address, in one cycle.
- Out-of-range address (>= DEPTH) on any enabled port:
  - Write is discarded.
  - Reserve is ignored.
  - Read returns 0 with hazard 0 and valid 1.
  - err is set and stays set until clr.
- busy reflects the registered scoreboard state. It is not combinationally affected by same-cycle strobes.
- A clr asserted while reads are in flight forces rd_valid to 0 on the next cycle. No stale data is presented.

Optional Feature:
REGFILE_R0_ZERO_EN
- Defined:
  - Register 0 reads as constant 0.
  - Writes to index 0 are discarded, with no bypass.
  - Reserves to index 0 are ignored, and busy[0] is constant 0.
  - Reads of index 0 never raise a hazard.
  - This supports Mini SRC base-address-zero addressing.
- Undefined: register 0 is an ordinary register, identical to all others.

Test Plan:
1. Reset, then read all 16 registers on both ports: rd_data = 0 each, rd_valid pulses 1 cycle after each rd_en, err = 0.
2. Write R5 = 0xDEADBEEF with the same-cycle rd_en_a on R5: next cycle rd_data_a = 0xDEADBEEF (bypass) and hazard_a = 0. A read one cycle later also returns 0xDEADBEEF.
3. Reserve R3, then read R3 on port B two cycles later: busy[3] = 1 and hazard_b = 1. Then write R3 = 0x12: busy[3] = 0, and a subsequent read gives 0x12 with hazard_b = 0.
4. Reserve and write R7 = 0x55 in the same cycle: R7 reads 0x55 and busy[7] remains 1.
5. With DEPTH = 12, ADDR_W = 4: write index 14 and read index 13. Storage is unchanged, rd_data = 0, and err = 1 until clr.
6. With REGFILE_R0_ZERO_EN: write R0 = 0xFFFFFFFF and reserve R0. R0 reads 0, busy[0] = 0, and hazard = 0. Without the macro, R0 reads 0xFFFFFFFF.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Register file with one write port, two registered read ports (write bypass) and a busy scoreboard.
// Optional macro REGFILE_R0_ZERO_EN hardwires register 0 to zero.
module regfile_scoreboard #(
  parameter int              WIDTH     = 32,
  parameter int              DEPTH     = 16,
  parameter int              ADDR_W    = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              rd_en_a,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [WIDTH-1:0]  rd_data_a,
  output logic              rd_valid_a,
  output logic              hazard_a,
  input  logic              rd_en_b,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_b,
  output logic              rd_valid_b,
  output logic              hazard_b,
  output logic [DEPTH-1:0]  busy,
  output logic              err
);

`ifdef REGFILE_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] r_busy;
  logic [WIDTH-1:0] r_data_a, r_data_b;
  logic             r_valid_a, r_valid_b, r_haz_a, r_haz_b, r_err;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_L);
  endfunction

  function automatic logic is_r0(input logic [ADDR_W-1:0] a);
    return R0_ZERO && (a == '0);
  endfunction

  logic             w_wr_in, w_rsv_in, w_a_in, w_b_in;
  logic             w_wr_ok, w_rsv_ok, w_a_hit, w_b_hit, w_a_haz, w_b_haz, w_err_hit;
  logic [WIDTH-1:0] w_a_data, w_b_data;
  logic [DEPTH-1:0] w_busy_nxt;

  assign w_wr_in  = in_range(wr_addr);
  assign w_rsv_in = in_range(rsv_addr);
  assign w_a_in   = in_range(rd_addr_a);
  assign w_b_in   = in_range(rd_addr_b);

  assign w_wr_ok  = wr_en && w_wr_in && !is_r0(wr_addr);
  assign w_rsv_ok = rsv_en && w_rsv_in && !is_r0(rsv_addr);

  // Bypass only from a write that will actually land in storage
  assign w_a_hit = w_wr_ok && (wr_addr == rd_addr_a);
  assign w_b_hit = w_wr_ok && (wr_addr == rd_addr_b);

  always_comb begin
    w_a_data = '0;
    w_a_haz  = 1'b0;
    if (w_a_in && !is_r0(rd_addr_a)) begin
      w_a_data = w_a_hit ? wr_data : r_mem[rd_addr_a];
      w_a_haz  = r_busy[rd_addr_a] && !w_a_hit;
    end
  end

  always_comb begin
    w_b_data = '0;
    w_b_haz  = 1'b0;
    if (w_b_in && !is_r0(rd_addr_b)) begin
      w_b_data = w_b_hit ? wr_data : r_mem[rd_addr_b];
      w_b_haz  = r_busy[rd_addr_b] && !w_b_hit;
    end
  end

  // Write-back clears first so a same-cycle reservation wins
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wr_ok)  w_busy_nxt[wr_addr]  = 1'b0;
    if (w_rsv_ok) w_busy_nxt[rsv_addr] = 1'b1;
  end

  assign w_err_hit = (wr_en && !w_wr_in) || (rsv_en && !w_rsv_in) ||
                     (rd_en_a && !w_a_in) || (rd_en_b && !w_b_in);

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= RESET_VAL;
    end else if (w_wr_ok) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_busy    <= '0;
      r_data_a  <= '0;
      r_data_b  <= '0;
      r_valid_a <= 1'b0;
      r_valid_b <= 1'b0;
      r_haz_a   <= 1'b0;
      r_haz_b   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_busy    <= w_busy_nxt;
      r_valid_a <= rd_en_a;
      r_valid_b <= rd_en_b;
      if (rd_en_a) begin
        r_data_a <= w_a_data;
        r_haz_a  <= w_a_haz;
      end
      if (rd_en_b) begin
        r_data_b <= w_b_data;
        r_haz_b  <= w_b_haz;
      end
      if (w_err_hit) r_err <= 1'b1;
    end
  end

  assign rd_data_a  = r_data_a;
  assign rd_valid_a = r_valid_a;
  assign hazard_a   = r_haz_a;
  assign rd_data_b  = r_data_b;
  assign rd_valid_b = r_valid_b;
  assign hazard_b   = r_haz_b;
  assign busy       = r_busy;
  assign err        = r_err;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: default 16-entry instance plus a 12-entry instance for range errors.
module tb_regfile_scoreboard;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 16-entry instance
  logic        clr, wr_en, rsv_en, rd_en_a, rd_en_b;
  logic [3:0]  wr_addr, rsv_addr, rd_addr_a, rd_addr_b;
  logic [31:0] wr_data, rd_data_a, rd_data_b;
  logic        rd_valid_a, rd_valid_b, hazard_a, hazard_b, err;
  logic [15:0] busy;

  // 12-entry instance
  logic        clr1, wr_en1, rsv_en1, rd_en_a1, rd_en_b1;
  logic [3:0]  wr_addr1, rsv_addr1, rd_addr_a1, rd_addr_b1;
  logic [31:0] wr_data1, rd_data_a1, rd_data_b1;
  logic        rd_valid_a1, rd_valid_b1, hazard_a1, hazard_b1, err1;
  logic [11:0] busy1;

  regfile_scoreboard dut (
    .clk(clk), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
    .rd_valid_a(rd_valid_a), .hazard_a(hazard_a),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
    .rd_valid_b(rd_valid_b), .hazard_b(hazard_b),
    .busy(busy), .err(err)
  );

  regfile_scoreboard #(.DEPTH(12)) dut12 (
    .clk(clk), .clr(clr1), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .rsv_en(rsv_en1), .rsv_addr(rsv_addr1),
    .rd_en_a(rd_en_a1), .rd_addr_a(rd_addr_a1), .rd_data_a(rd_data_a1),
    .rd_valid_a(rd_valid_a1), .hazard_a(hazard_a1),
    .rd_en_b(rd_en_b1), .rd_addr_b(rd_addr_b1), .rd_data_b(rd_data_b1),
    .rd_valid_b(rd_valid_b1), .hazard_b(hazard_b1),
    .busy(busy1), .err(err1)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clr = 0; wr_en = 0; rsv_en = 0; rd_en_a = 0; rd_en_b = 0;
    wr_addr = 0; rsv_addr = 0; rd_addr_a = 0; rd_addr_b = 0; wr_data = 0;
    clr1 = 0; wr_en1 = 0; rsv_en1 = 0; rd_en_a1 = 0; rd_en_b1 = 0;
    wr_addr1 = 0; rsv_addr1 = 0; rd_addr_a1 = 0; rd_addr_b1 = 0; wr_data1 = 0;
  endtask

  task automatic test_reset();
    idle();
    clr = 1; clr1 = 1;
    cycle();
    idle();
    checks++; if (busy !== 16'h0) begin errors++; $display("FAIL reset_busy got=%h exp=0", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (rd_valid_a !== 1'b0 || rd_valid_b !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b%b exp=00", rd_valid_a, rd_valid_b); end
    checks++; if (rd_data_a !== 32'h0 || hazard_a !== 1'b0) begin errors++; $display("FAIL reset_data_a got=%h/%b exp=0/0", rd_data_a, hazard_a); end
    checks++; if (busy1 !== 12'h0 || err1 !== 1'b0) begin errors++; $display("FAIL reset_dut12 got=%h/%b exp=0/0", busy1, err1); end
  endtask

  task automatic test_read_all();
    for (int i = 0; i < 16; i++) begin
      rd_en_a = 1; rd_addr_a = 4'(i);
      rd_en_b = 1; rd_addr_b = 4'(15 - i);
      cycle();
      checks++; if (rd_data_a !== 32'h0 || rd_valid_a !== 1'b1) begin errors++; $display("FAIL read_all_a[%0d] got=%h/%b exp=0/1", i, rd_data_a, rd_valid_a); end
      checks++; if (rd_data_b !== 32'h0 || rd_valid_b !== 1'b1) begin errors++; $display("FAIL read_all_b[%0d] got=%h/%b exp=0/1", 15 - i, rd_data_b, rd_valid_b); end
    end
    idle();
    cycle();
    checks++; if (rd_valid_a !== 1'b0 || rd_valid_b !== 1'b0) begin errors++; $display("FAIL read_all_valid_drop got=%b%b exp=00", rd_valid_a, rd_valid_b); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL read_all_err got=%b exp=0", err); end
  endtask

  task automatic test_bypass();
    wr_en = 1; wr_addr = 4'd5; wr_data = 32'hDEADBEEF;
    rd_en_a = 1; rd_addr_a = 4'd5;
    cycle();
    idle();
    checks++; if (rd_data_a !== 32'hDEADBEEF || hazard_a !== 1'b0 || rd_valid_a !== 1'b1) begin errors++; $display("FAIL bypass_r5 got=%h/%b/%b exp=deadbeef/0/1", rd_data_a, hazard_a, rd_valid_a); end
    rd_en_a = 1; rd_addr_a = 4'd5;
    cycle();
    idle();
    checks++; if (rd_data_a !== 32'hDEADBEEF || hazard_a !== 1'b0) begin errors++; $display("FAIL stored_r5 got=%h/%b exp=deadbeef/0", rd_data_a, hazard_a); end
    cycle();
    checks++; if (rd_data_a !== 32'hDEADBEEF || rd_valid_a !== 1'b0) begin errors++; $display("FAIL hold_a got=%h/%b exp=deadbeef/0", rd_data_a, rd_valid_a); end
  endtask

  task automatic test_scoreboard();
    rsv_en = 1; rsv_addr = 4'd3;
    cycle();
    idle();
    cycle();
    rd_en_b = 1; rd_addr_b = 4'd3;
    cycle();
    idle();
    checks++; if (busy[3] !== 1'b1) begin errors++; $display("FAIL rsv_busy3 got=%b exp=1", busy[3]); end
    checks++; if (hazard_b !== 1'b1 || rd_data_b !== 32'h0) begin errors++; $display("FAIL rsv_hazard_b got=%b/%h exp=1/0", hazard_b, rd_data_b); end
    rsv_en = 1; rsv_addr = 4'd3;
    cycle();
    idle();
    checks++; if (busy !== 16'h0008 || err !== 1'b0) begin errors++; $display("FAIL rsv_again got=%h/%b exp=0008/0", busy, err); end
    wr_en = 1; wr_addr = 4'd3; wr_data = 32'h12;
    cycle();
    idle();
    checks++; if (busy[3] !== 1'b0) begin errors++; $display("FAIL wb_clear3 got=%b exp=0", busy[3]); end
    rd_en_b = 1; rd_addr_b = 4'd3;
    cycle();
    idle();
    checks++; if (rd_data_b !== 32'h12 || hazard_b !== 1'b0) begin errors++; $display("FAIL wb_read3 got=%h/%b exp=12/0", rd_data_b, hazard_b); end
  endtask

  task automatic test_rsv_wr_same();
    rsv_en = 1; rsv_addr = 4'd7;
    wr_en = 1; wr_addr = 4'd7; wr_data = 32'h55;
    cycle();
    idle();
    checks++; if (busy !== 16'h0080) begin errors++; $display("FAIL rsv_wr_busy got=%h exp=0080", busy); end
    rd_en_a = 1; rd_addr_a = 4'd7;
    cycle();
    idle();
    checks++; if (rd_data_a !== 32'h55 || hazard_a !== 1'b1) begin errors++; $display("FAIL rsv_wr_read got=%h/%b exp=55/1", rd_data_a, hazard_a); end
  endtask

  task automatic test_back_to_back();
    wr_en = 1; wr_addr = 4'd9; wr_data = 32'hA5A5_0001;
    rd_en_a = 1; rd_addr_a = 4'd9;
    rd_en_b = 1; rd_addr_b = 4'd9;
    cycle();
    wr_en = 1; wr_addr = 4'd9; wr_data = 32'h0000_5A5A;
    rd_en_a = 1; rd_addr_a = 4'd9;
    rd_en_b = 1; rd_addr_b = 4'd5;
    cycle();
    idle();
    checks++; if (rd_data_a !== 32'h0000_5A5A || rd_data_b !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_second got=%h/%h exp=00005a5a/deadbeef", rd_data_a, rd_data_b); end
    checks++; if (rd_valid_a !== 1'b1 || rd_valid_b !== 1'b1 || hazard_a !== 1'b0) begin errors++; $display("FAIL b2b_flags got=%b%b%b exp=110", rd_valid_a, rd_valid_b, hazard_a); end
    rd_en_b = 1; rd_addr_b = 4'd9;
    cycle();
    idle();
    checks++; if (rd_data_b !== 32'h0000_5A5A) begin errors++; $display("FAIL b2b_stored got=%h exp=00005a5a", rd_data_b); end
  endtask

  task automatic test_r0();
    wr_en = 1; wr_addr = 4'd0; wr_data = 32'hFFFFFFFF;
    rsv_en = 1; rsv_addr = 4'd0;
    rd_en_a = 1; rd_addr_a = 4'd0;
    cycle();
    idle();
`ifdef REGFILE_R0_ZERO_EN
    checks++; if (rd_data_a !== 32'h0 || hazard_a !== 1'b0) begin errors++; $display("FAIL r0_nobypass got=%h/%b exp=0/0", rd_data_a, hazard_a); end
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL r0_busy got=%b exp=0", busy[0]); end
`else
    checks++; if (rd_data_a !== 32'hFFFFFFFF || hazard_a !== 1'b0) begin errors++; $display("FAIL r0_bypass got=%h/%b exp=ffffffff/0", rd_data_a, hazard_a); end
    checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL r0_busy got=%b exp=1", busy[0]); end
`endif
    rd_en_b = 1; rd_addr_b = 4'd0;
    cycle();
    idle();
`ifdef REGFILE_R0_ZERO_EN
    checks++; if (rd_data_b !== 32'h0 || hazard_b !== 1'b0) begin errors++; $display("FAIL r0_read got=%h/%b exp=0/0", rd_data_b, hazard_b); end
`else
    checks++; if (rd_data_b !== 32'hFFFFFFFF || hazard_b !== 1'b1) begin errors++; $display("FAIL r0_read got=%h/%b exp=ffffffff/1", rd_data_b, hazard_b); end
`endif
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL r0_err got=%b exp=0", err); end
  endtask

  task automatic test_clr_inflight();
    rd_en_a = 1; rd_addr_a = 4'd5;
    rd_en_b = 1; rd_addr_b = 4'd7;
    rsv_en = 1; rsv_addr = 4'd2;
    clr = 1;
    cycle();
    idle();
    checks++; if (rd_valid_a !== 1'b0 || rd_valid_b !== 1'b0) begin errors++; $display("FAIL clr_valid got=%b%b exp=00", rd_valid_a, rd_valid_b); end
    checks++; if (rd_data_a !== 32'h0 || rd_data_b !== 32'h0 || busy !== 16'h0) begin errors++; $display("FAIL clr_state got=%h/%h/%h exp=0/0/0", rd_data_a, rd_data_b, busy); end
    rd_en_a = 1; rd_addr_a = 4'd5;
    cycle();
    idle();
    checks++; if (rd_data_a !== 32'h0 || rd_valid_a !== 1'b1) begin errors++; $display("FAIL clr_storage got=%h/%b exp=0/1", rd_data_a, rd_valid_a); end
  endtask

  task automatic test_out_of_range();
    wr_en1 = 1; wr_addr1 = 4'd2; wr_data1 = 32'h77;
    cycle();
    idle();
    checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL oor_pre_err got=%b exp=0", err1); end
    wr_en1 = 1; wr_addr1 = 4'd14; wr_data1 = 32'hBAD;
    rsv_en1 = 1; rsv_addr1 = 4'd12;
    rd_en_a1 = 1; rd_addr_a1 = 4'd13;
    rd_en_b1 = 1; rd_addr_b1 = 4'd2;
    cycle();
    idle();
    checks++; if (rd_data_a1 !== 32'h0 || hazard_a1 !== 1'b0 || rd_valid_a1 !== 1'b1) begin errors++; $display("FAIL oor_read got=%h/%b/%b exp=0/0/1", rd_data_a1, hazard_a1, rd_valid_a1); end
    checks++; if (rd_data_b1 !== 32'h77) begin errors++; $display("FAIL oor_inrange_read got=%h exp=77", rd_data_b1); end
    checks++; if (err1 !== 1'b1 || busy1 !== 12'h0) begin errors++; $display("FAIL oor_err_busy got=%b/%h exp=1/000", err1, busy1); end
    for (int i = 0; i < 12; i++) begin
      rd_en_a1 = 1; rd_addr_a1 = 4'(i);
      cycle();
      checks++; if (rd_data_a1 !== ((i == 2) ? 32'h77 : 32'h0)) begin errors++; $display("FAIL oor_storage[%0d] got=%h", i, rd_data_a1); end
    end
    idle();
    cycle();
    checks++; if (err1 !== 1'b1) begin errors++; $display("FAIL oor_sticky got=%b exp=1", err1); end
    clr1 = 1;
    cycle();
    idle();
    checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL oor_clr got=%b exp=0", err1); end
  endtask

  initial begin
    test_reset();
    test_read_all();
    test_bypass();
    test_scoreboard();
    test_rsv_wr_same();
    test_back_to_back();
    test_r0();
    test_clr_inflight();
    test_out_of_range();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
